// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the MIPS instruction fetch stage: opcode layout,
// HALT and NOP encodings, and the fetch state machine encoding.
package instruction_fetch_pkg;

    localparam int NB_OPCODE = 6;

    localparam logic [NB_OPCODE-1:0] HALT_OPCODE = 6'b111111;
    localparam logic [31:0]          NOP_WORD    = 32'h0000_0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of fetch-stage control, programming and IF/ID signals shared between
// the IF stage (slave) and the hazard/decode/debug logic that drives it (master).
interface instruction_fetch_if #(
    parameter int NB          = 32,
    parameter int NB_MEM_ADDR = 8
);
    logic                   i_enable;
    logic                   i_stall;
    logic                   i_redirect;
    logic [NB-1:0]          i_redirect_target;
    logic                   i_mem_wr_en;
    logic [NB_MEM_ADDR-1:0] i_mem_wr_addr;
    logic [NB-1:0]          i_mem_wr_data;
    logic [NB-1:0]          o_instruction;
    logic [NB-1:0]          o_pc_plus4;
    logic                   o_valid;
    logic [NB-1:0]          o_pc;
    logic                   o_halted;

    modport master (
        output i_enable, i_stall, i_redirect, i_redirect_target,
        output i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data,
        input  o_instruction, o_pc_plus4, o_valid, o_pc, o_halted
    );

    modport slave (
        input  i_enable, i_stall, i_redirect, i_redirect_target,
        input  i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data,
        output o_instruction, o_pc_plus4, o_valid, o_pc, o_halted
    );

endinterface

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: synchronous write port for debug programming,
// combinational read port for fetch. Contents survive reset.
module instruction_memory #(
    parameter int NB          = 32,
    parameter int NB_MEM_ADDR = 8
) (
    input  logic                   i_clk,
    input  logic                   wr_en,
    input  logic [NB_MEM_ADDR-1:0] wr_addr,
    input  logic [NB-1:0]          wr_data,
    input  logic [NB_MEM_ADDR-1:0] rd_addr,
    output logic [NB-1:0]          rd_data
);

    logic [NB-1:0] mem [2**NB_MEM_ADDR];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the five-stage MIPS pipeline: PC, instruction memory and IF/ID register.
// Optional HALT detection and HALTED state enabled by defining IFETCH_HALT_DETECT_EN.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int NB          = 32,
    parameter int NB_MEM_ADDR = 8
) (
    input logic               i_clk,
    input logic               i_reset,
    instruction_fetch_if.slave bus
);

    logic [NB-1:0] pc;
    logic [NB-1:0] pc_plus4;
    logic [NB-1:0] fetch_word;
    logic [NB-1:0] redirect_pc;
    logic [NB-1:0] if_id_instruction;
    logic [NB-1:0] if_id_pc_plus4;
    logic          if_id_valid;
    logic          mem_wr_en;
    logic          halt_hit;
    logic          halted;

    // Programming is only allowed while the pipeline is frozen by the debug unit.
    assign mem_wr_en   = bus.i_mem_wr_en & ~bus.i_enable;
    assign pc_plus4    = pc + NB'(4);
    assign redirect_pc = bus.i_redirect_target & ~NB'(3);

    instruction_memory #(
        .NB          (NB),
        .NB_MEM_ADDR (NB_MEM_ADDR)
    ) u_instruction_memory (
        .i_clk   (i_clk),
        .wr_en   (mem_wr_en),
        .wr_addr (bus.i_mem_wr_addr),
        .wr_data (bus.i_mem_wr_data),
        .rd_addr (pc[NB_MEM_ADDR+1:2]),
        .rd_data (fetch_word)
    );

`ifdef IFETCH_HALT_DETECT_EN
    fetch_state_t state;

    assign halt_hit = (fetch_word[NB-1 -: NB_OPCODE] == HALT_OPCODE);
    assign halted   = (state == ST_HALTED);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_RUN;
        end else if (bus.i_enable) begin
            case (state)
                ST_RUN: begin
                    if (!bus.i_stall && !bus.i_redirect && halt_hit) begin
                        state <= ST_HALTED;
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // Redirects squash the wrong-path fetch with a bubble; HALT keeps the PC pointing at itself.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc                <= '0;
            if_id_instruction <= '0;
            if_id_pc_plus4    <= '0;
            if_id_valid       <= 1'b0;
        end else if (bus.i_enable) begin
            if (halted) begin
                if_id_instruction <= NB'(NOP_WORD);
                if_id_pc_plus4    <= '0;
                if_id_valid       <= 1'b0;
            end else if (!bus.i_stall) begin
                if (bus.i_redirect) begin
                    pc                <= redirect_pc;
                    if_id_instruction <= NB'(NOP_WORD);
                    if_id_pc_plus4    <= '0;
                    if_id_valid       <= 1'b0;
                end else begin
                    if_id_instruction <= fetch_word;
                    if_id_pc_plus4    <= pc_plus4;
                    if_id_valid       <= 1'b1;
                    if (!halt_hit) begin
                        pc <= pc_plus4;
                    end
                end
            end
        end
    end

    assign bus.o_instruction = if_id_instruction;
    assign bus.o_pc_plus4    = if_id_pc_plus4;
    assign bus.o_valid       = if_id_valid;
    assign bus.o_pc          = pc;
    assign bus.o_halted      = halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: table-driven vectors through a scoreboard
// queue plus hand-written HALT and asynchronous-reset sequences.
module tb_instruction_fetch;

`ifdef IFETCH_HALT_DETECT_EN
    localparam bit HALT_ON = 1'b1;
`else
    localparam bit HALT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instruction_fetch_if #(.NB(32), .NB_MEM_ADDR(8)) bus ();

    instruction_fetch #(.NB(32), .NB_MEM_ADDR(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic        en;
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
        logic [31:0] pc;
        logic        halted;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
        logic [31:0] pc;
        logic        halted;
    } exp_t;

    exp_t        sb[$];
    vec_t        vectors[$];
    logic [31:0] mem_m [256];
    int          checks   = 0;
    int          failures = 0;

    function automatic vec_t mkVec(string n, bit en, bit st, bit rd, logic [31:0] tg,
                                   logic [31:0] ins, logic [31:0] pp, bit vl,
                                   logic [31:0] pcv, bit h);
        vec_t v;
        v.name   = n;
        v.en     = en;
        v.stall  = st;
        v.redir  = rd;
        v.target = tg;
        v.instr  = ins;
        v.pp4    = pp;
        v.valid  = vl;
        v.pc     = pcv;
        v.halted = h;
        return v;
    endfunction

    task automatic checkField(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector's inputs and queue what the IF/ID outputs must show after the edge.
    task automatic applyStimulus(vec_t v);
        exp_t e;
        bus.i_enable          = v.en;
        bus.i_stall           = v.stall;
        bus.i_redirect        = v.redir;
        bus.i_redirect_target = v.target;
        e.name   = v.name;
        e.instr  = v.instr;
        e.pp4    = v.pp4;
        e.valid  = v.valid;
        e.pc     = v.pc;
        e.halted = v.halted;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        checkField({e.name, ".instr"},  bus.o_instruction,    e.instr);
        checkField({e.name, ".pp4"},    bus.o_pc_plus4,       e.pp4);
        checkField({e.name, ".valid"},  32'(bus.o_valid),     32'(e.valid));
        checkField({e.name, ".pc"},     bus.o_pc,             e.pc);
        checkField({e.name, ".halted"}, 32'(bus.o_halted),    32'(e.halted));
    endtask

    task automatic runVec(vec_t v);
        applyStimulus(v);
        tick();
        checkOutput();
    endtask

    task automatic checkResetValues(string tag);
        checkField({tag, ".instr"},  bus.o_instruction, 32'h0);
        checkField({tag, ".pp4"},    bus.o_pc_plus4,    32'h0);
        checkField({tag, ".valid"},  32'(bus.o_valid),  32'h0);
        checkField({tag, ".pc"},     bus.o_pc,          32'h0);
        checkField({tag, ".halted"}, 32'(bus.o_halted), 32'h0);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem_m[k] = 32'h1000_0000 | 32'(k);
        mem_m[0]  = 32'h2001_0005;
        mem_m[1]  = 32'h2002_0003;
        mem_m[2]  = 32'h0022_1820;
        mem_m[3]  = 32'hFC00_0000;
        mem_m[16] = 32'h2003_000A;
        mem_m[17] = 32'h2004_000B;

        rst                   = 1'b1;
        bus.i_enable          = 1'b0;
        bus.i_stall           = 1'b0;
        bus.i_redirect        = 1'b0;
        bus.i_redirect_target = '0;
        bus.i_mem_wr_en       = 1'b0;
        bus.i_mem_wr_addr     = '0;
        bus.i_mem_wr_data     = '0;
        tick();
        checkResetValues("reset");
        rst = 1'b0;
        tick();

        for (int k = 0; k < 256; k++) begin
            bus.i_mem_wr_en   = 1'b1;
            bus.i_mem_wr_addr = 8'(k);
            bus.i_mem_wr_data = mem_m[k];
            tick();
        end
        bus.i_mem_wr_en = 1'b0;
        checkField("program.pc",    bus.o_pc,         32'h0);
        checkField("program.valid", 32'(bus.o_valid), 32'h0);

        vectors.push_back(mkVec("run0",       1,0,0,32'h0,        mem_m[0],  32'h4, 1,32'h4,        0));
        vectors.push_back(mkVec("run1",       1,0,0,32'h0,        mem_m[1],  32'h8, 1,32'h8,        0));
        vectors.push_back(mkVec("stall0",     1,1,0,32'h0,        mem_m[1],  32'h8, 1,32'h8,        0));
        vectors.push_back(mkVec("stall1",     1,1,0,32'h0,        mem_m[1],  32'h8, 1,32'h8,        0));
        vectors.push_back(mkVec("resume",     1,0,0,32'h0,        mem_m[2],  32'hC, 1,32'hC,        0));
        vectors.push_back(mkVec("redir41",    1,0,1,32'h41,       32'h0,     32'h0, 0,32'h40,       0));
        vectors.push_back(mkVec("target16",   1,0,0,32'h0,        mem_m[16], 32'h44,1,32'h44,       0));
        vectors.push_back(mkVec("stallredir", 1,1,1,32'h8,        mem_m[16], 32'h44,1,32'h44,       0));
        vectors.push_back(mkVec("after17",    1,0,0,32'h0,        mem_m[17], 32'h48,1,32'h48,       0));
        vectors.push_back(mkVec("disabled",   0,0,1,32'h8,        mem_m[17], 32'h48,1,32'h48,       0));
        vectors.push_back(mkVec("redir4",     1,0,1,32'h4,        32'h0,     32'h0, 0,32'h4,        0));
        vectors.push_back(mkVec("fetch1",     1,0,0,32'h0,        mem_m[1],  32'h8, 1,32'h8,        0));
        vectors.push_back(mkVec("redirwrap",  1,0,1,32'hFFFF_FFFE,32'h0,     32'h0, 0,32'hFFFF_FFFC,0));
        vectors.push_back(mkVec("wrapfetch",  1,0,0,32'h0,        mem_m[255],32'h0, 1,32'h0,        0));
        vectors.push_back(mkVec("again0",     1,0,0,32'h0,        mem_m[0],  32'h4, 1,32'h4,        0));
        vectors.push_back(mkVec("again1",     1,0,0,32'h0,        mem_m[1],  32'h8, 1,32'h8,        0));
        vectors.push_back(mkVec("again2",     1,0,0,32'h0,        mem_m[2],  32'hC, 1,32'hC,        0));
        foreach (vectors[i]) runVec(vectors[i]);

        // HALT word at 0x0C: frozen PC and drained bubbles with detection, plain advance without.
        runVec(mkVec("halt", 1,0,0,32'h0, mem_m[3], 32'h10, 1,
                     HALT_ON ? 32'hC : 32'h10, HALT_ON));
        runVec(mkVec("drain0", 1,0,0,32'h0,
                     HALT_ON ? 32'h0 : mem_m[4], HALT_ON ? 32'h0 : 32'h14, !HALT_ON,
                     HALT_ON ? 32'hC : 32'h14, HALT_ON));
        runVec(mkVec("drain1", 1,1,1,32'h80,
                     HALT_ON ? 32'h0 : mem_m[4], HALT_ON ? 32'h0 : 32'h14, !HALT_ON,
                     HALT_ON ? 32'hC : 32'h14, HALT_ON));
        bus.i_mem_wr_en   = 1'b1;
        bus.i_mem_wr_addr = 8'h00;
        bus.i_mem_wr_data = 32'hDEAD_BEEF;
        runVec(mkVec("wrignored", 1,0,0,32'h0,
                     HALT_ON ? 32'h0 : mem_m[5], HALT_ON ? 32'h0 : 32'h18, !HALT_ON,
                     HALT_ON ? 32'hC : 32'h18, HALT_ON));
        bus.i_mem_wr_en = 1'b0;

        // Reset exits HALTED; run to PC=8, then reset between edges and re-run from intact memory.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        runVec(mkVec("rerun0", 1,0,0,32'h0, mem_m[0], 32'h4, 1, 32'h4, 0));
        runVec(mkVec("rerun1", 1,0,0,32'h0, mem_m[1], 32'h8, 1, 32'h8, 0));
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("asyncreset");
        tick();
        rst = 1'b0;
        runVec(mkVec("post0", 1,0,0,32'h0, mem_m[0], 32'h4, 1, 32'h4, 0));
        runVec(mkVec("post1", 1,0,0,32'h0, mem_m[1], 32'h8, 1, 32'h8, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL timeout: got no completion, expected finish before 50000");
        $fatal(1, "[TB] timeout");
    end

endmodule
